// File: rtl/sample_framer.sv
// sample_framer: buffers strobed samples in a FIFO and emits framed packets
// of header (mode tag), FRAME_LEN payload bytes and an XOR checksum.
module sample_framer #(
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    d_in,
  input  logic [2:0]                    mode,
  input  logic                          sample_stb,
  input  logic                          tx_ready,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CSUM} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [7:0]    csum_q, csum_d, data_q, data_d;
  logic [2:0]    hdr_q, hdr_d;
  logic          ovf_q, ovf_d, valid_q, valid_d, last_q, last_d;
  logic          hs, push, pop;
  always_comb begin
    hs      = valid_q && tx_ready;
    push    = sample_stb && (cnt_q < CW'(FIFO_DEPTH));
    pop     = hs && (state_q == PAYLOAD);
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q || (sample_stb && !push);
    state_d = state_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (!valid_q && cnt_q >= CW'(FRAME_LEN)) begin
        state_d = HDR;
        hdr_d   = mode;
        valid_d = 1'b1;
        data_d  = {5'b10100, mode};
      end
      HDR: if (hs) begin
        state_d = PAYLOAD;
        csum_d  = data_q;
        idx_d   = '0;
        data_d  = mem[rd_q];
      end
      PAYLOAD: if (hs) begin
        csum_d = csum_q ^ data_q;
        idx_d  = idx_q + 1'b1;
        // the FIFO held a full frame when the header started, so rd_q+1 is valid
        if (idx_q == CW'(FRAME_LEN - 1)) begin
          state_d = CSUM;
          data_d  = csum_q ^ data_q;
          last_d  = 1'b1;
        end else begin
          data_d = mem[rd_q + 1'b1];
        end
      end
      CSUM: if (hs) begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = 8'h00;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= d_in;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      csum_q  <= 8'h00;
      data_q  <= 8'h00;
      hdr_q   <= 3'd0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
  assign tx_valid   = valid_q;
  assign tx_data    = data_q;
  assign tx_last    = last_q;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: vector table for the basic frame plus directed sequences
// for stalls, overflow, mode capture, mid-frame reset and push-while-drain.
module tb_sample_framer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d_in;
  logic [2:0] mode;
  logic       sample_stb, tx_ready;
  logic       tx_valid, tx_last, overflow;
  logic [7:0] tx_data;
  logic [3:0] fifo_count;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] rx_q[$];
  logic       rl_q[$];

  sample_framer #(.FRAME_LEN(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .mode(mode), .sample_stb(sample_stb),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stb;
    logic [7:0] d;
    logic [2:0] m;
    logic       rdy;
    logic       v;
    logic [7:0] data;
    logic       last;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    sample_stb = 1'b0;
    tx_ready = 1'b0;
    d_in = 8'h00;
    mode = 3'd0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic push4(input logic [7:0] a, b, c, d);
    logic [7:0] s[4];
    s = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      sample_stb = 1'b1;
      d_in = s[i];
      tick;
    end
    sample_stb = 1'b0;
  endtask

  // collects n handshaken bytes; stall applies the ready pattern 1,0,0,1
  task automatic drain(input bit stall, input int n);
    int c;
    bit hold;
    logic [7:0] hd;
    logic hl;
    c = 0;
    hold = 1'b0;
    hd = 8'h00;
    hl = 1'b0;
    rx_q.delete();
    rl_q.delete();
    while (rx_q.size() < n && c < 100) begin
      tx_ready = stall ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      if (hold) chk("stall_hold", {23'd0, tx_valid, tx_last, tx_data}, {23'd0, 1'b1, hl, hd});
      if (tx_valid && tx_ready) begin
        rx_q.push_back(tx_data);
        rl_q.push_back(tx_last);
      end
      hold = tx_valid && !tx_ready;
      hd = tx_data;
      hl = tx_last;
      tick;
      c++;
    end
    if (c >= 100) chk("drain_timeout", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic check_frame(input string name, input logic [7:0] exp[6], input int base);
    for (int i = 0; i < 6; i++) begin
      if (base + i < rx_q.size()) begin
        chk(name, {24'd0, rx_q[base+i]}, {24'd0, exp[i]});
        chk({name, "_last"}, {31'd0, rl_q[base+i]}, {31'd0, i == 5});
      end else chk({name, "_missing"}, 32'(rx_q.size()), 32'(base + 6));
    end
  endtask

  task automatic wait_valid(input string name);
    int c;
    c = 0;
    while (!tx_valid && c < 20) begin
      tick;
      c++;
    end
    chk(name, {31'd0, tx_valid}, 32'd1);
  endtask

  initial begin
    logic [7:0] f[6];
    logic [7:0] p[4];
    rst = 1'b0;
    sample_stb = 1'b0;
    tx_ready = 1'b0;
    d_in = 8'h00;
    mode = 3'd0;
    #3;
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_last", {31'd0, tx_last}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_count", {28'd0, fifo_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);

    // basic frame, mode 1, ready high
    tbl[0]  = '{1'b1, 8'h11, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1};
    tbl[1]  = '{1'b1, 8'h22, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd2};
    tbl[2]  = '{1'b1, 8'h33, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd3};
    tbl[3]  = '{1'b1, 8'h44, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd4};
    tbl[4]  = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b1, 8'hA1, 1'b0, 4'd4};
    tbl[5]  = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b1, 8'h11, 1'b0, 4'd4};
    tbl[6]  = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b1, 8'h22, 1'b0, 4'd3};
    tbl[7]  = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b1, 8'h33, 1'b0, 4'd2};
    tbl[8]  = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b1, 8'h44, 1'b0, 4'd1};
    tbl[9]  = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b1, 8'hE5, 1'b1, 4'd0};
    tbl[10] = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0};
    tick;
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      sample_stb = tbl[i].stb;
      d_in = tbl[i].d;
      mode = tbl[i].m;
      tx_ready = tbl[i].rdy;
      tick;
      chk($sformatf("vec%0d_valid", i), {31'd0, tx_valid}, {31'd0, tbl[i].v});
      if (tbl[i].v) chk($sformatf("vec%0d_data", i), {24'd0, tx_data}, {24'd0, tbl[i].data});
      chk($sformatf("vec%0d_last", i), {31'd0, tx_last}, {31'd0, tbl[i].last});
      chk($sformatf("vec%0d_count", i), {28'd0, fifo_count}, {28'd0, tbl[i].cnt});
    end

    // same frame under a 1,0,0,1 ready pattern
    do_reset;
    mode = 3'd1;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    drain(1'b1, 6);
    f = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE5};
    check_frame("stall_frame", f, 0);

    // overflow: 9 strobes with downstream blocked
    do_reset;
    for (int i = 1; i <= 9; i++) begin
      sample_stb = 1'b1;
      d_in = 8'(i);
      tick;
    end
    sample_stb = 1'b0;
    chk("ovf_count", {28'd0, fifo_count}, 32'd8);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    drain(1'b0, 12);
    f = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA4};
    check_frame("ovf_frame1", f, 0);
    f = '{8'hA0, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAC};
    check_frame("ovf_frame2", f, 6);
    for (int i = 0; i < 6; i++) tick;
    chk("ovf_no_extra", {31'd0, tx_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_empty", {28'd0, fifo_count}, 32'd0);

    // mode change after header handshake, pushing every cycle while draining
    do_reset;
    tx_ready = 1'b1;
    push4(8'h10, 8'h20, 8'h30, 8'h40);
    wait_valid("mode_hdr_valid");
    chk("mode_hdr0", {24'd0, tx_data}, 32'hA0);
    tick;
    mode = 3'd2;
    p = '{8'h50, 8'h60, 8'h70, 8'h80};
    f = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_data%0d", i), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, f[i]});
      sample_stb = 1'b1;
      d_in = p[i];
      tick;
      chk($sformatf("pp_count%0d", i), {28'd0, fifo_count}, 32'd4);
    end
    sample_stb = 1'b0;
    drain(1'b0, 1);
    if (rx_q.size() == 1) begin
      chk("pp_csum", {24'd0, rx_q[0]}, 32'hE0);
      chk("pp_csum_last", {31'd0, rl_q[0]}, 32'd1);
    end
    drain(1'b0, 6);
    f = '{8'hA2, 8'h50, 8'h60, 8'h70, 8'h80, 8'h62};
    check_frame("mode_frame2", f, 0);
    chk("pp_no_ovf", {31'd0, overflow}, 32'd0);

    // asynchronous reset in the middle of the payload
    do_reset;
    tx_ready = 1'b1;
    push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    wait_valid("mid_hdr_valid");
    tick;
    tick;
    chk("mid_in_payload", {24'd0, tx_data}, 32'hBB);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_count", {28'd0, fifo_count}, 32'd0);
    chk("mid_rst_data", {24'd0, tx_data}, 32'd0);
    tick;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    chk("mid_no_partial", {31'd0, tx_valid}, 32'd0);
    mode = 3'd5;
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    drain(1'b0, 6);
    f = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA1};
    check_frame("mid_frame", f, 0);
    chk("mid_end_count", {28'd0, fifo_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001: The block SHALL have parameter FRAME_LEN, default 4, meaning payload bytes per frame (legal 1..FIFO_DEPTH).
REQ-002: The block SHALL have parameter FIFO_DEPTH, default 8, meaning sample buffer entries (power of two, 2..16).
REQ-003: The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004: The block SHALL have port rst, input, 1, reset: asynchronous and active-low.
REQ-005: The block SHALL have port d_in, input, 8, the selected data byte from the upstream source-select stage.
REQ-006: The block SHALL have port mode, input, 3, the upstream source-select code, carried in the frame header.
REQ-007: The block SHALL have port sample_stb, input, 1, a one-cycle pulse meaning d_in holds a new sample.
REQ-008: The block SHALL have port tx_ready, input, 1, downstream accepts the byte when high with tx_valid.
REQ-009: The block SHALL have port tx_valid, output, 1, meaning tx_data holds a valid frame byte.
REQ-010: The block SHALL have port tx_data, output, 8, the frame byte.
REQ-011: The block SHALL have port tx_last, output, 1, high on the checksum byte (last byte of frame).
REQ-012: The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, the number of buffered samples.
REQ-013: The block SHALL have port overflow, output, 1, sticky flag meaning a sample was dropped.

Function
REQ-014: On a clk edge with sample_stb=1, the block SHALL write d_in to the FIFO tail if fifo_count < FIFO_DEPTH, evaluated before any same-cycle pop.
REQ-015: When sample_stb=1 arrives with the FIFO full, the block SHALL drop the sample and set overflow; overflow clears only on reset.
REQ-016: On a simultaneous push and pop (FIFO not full), both SHALL take effect and fifo_count SHALL stay unchanged.
REQ-017: The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018: A handshake SHALL occur on an edge where tx_valid=1 and tx_ready=1.
REQ-019: While tx_valid=1 and tx_ready=0, tx_data and tx_last SHALL hold stable.
REQ-020: tx_valid, tx_data and tx_last SHALL have no combinational path from tx_ready.
REQ-021: The FSM SHALL have the states IDLE, HDR, PAYLOAD and CSUM.
REQ-022: In IDLE, with tx_valid=0, the FSM SHALL move to HDR when fifo_count >= FRAME_LEN, and SHALL latch mode into hdr_mode on that edge.
REQ-023: In HDR, the block SHALL drive tx_valid=1 and tx_data={5'b10100, hdr_mode}.
REQ-024: On the HDR handshake, the block SHALL set checksum = header byte and byte index = 0, and move to PAYLOAD.
REQ-025: In PAYLOAD, the block SHALL drive tx_valid=1 and tx_data = FIFO head.
REQ-026: On each PAYLOAD handshake, the block SHALL pop the FIFO, XOR the byte into checksum, and increment the index; after handshake FRAME_LEN-1 it SHALL move to CSUM.
REQ-027: In CSUM, the block SHALL drive tx_valid=1, tx_data = checksum and tx_last=1.
REQ-028: On the CSUM handshake, the FSM SHALL return to IDLE, giving a minimum one-cycle gap between frames.
REQ-029: Changes on mode during a frame SHALL NOT affect that frame's header.
REQ-030: With tx_ready held high, tx_valid SHALL rise one cycle after fifo_count first reaches FRAME_LEN, and a frame SHALL take FRAME_LEN+2 consecutive cycles.
REQ-031: The FIFO SHALL keep accepting samples during a frame, subject to REQ-014 and REQ-015.

Reset
REQ-032: While rst=0, the block SHALL set the FSM to IDLE, the FIFO pointers and fifo_count to 0, checksum, index and hdr_mode to 0, tx_valid=0, tx_last=0, tx_data=8'h00 and overflow=0, with no clk needed.
REQ-033: Asserting reset mid-frame SHALL abort the frame and discard buffered samples; after deassertion no partial frame bytes SHALL be emitted.

Verification
REQ-034: Scenario: mode=3'b001, samples 11,22,33,44, tx_ready=1 -> bytes A1,11,22,33,44,E5 with tx_last only on E5, and fifo_count returns to 0.
REQ-035: Scenario: same frame with tx_ready toggling 1,0,0,1 per cycle -> identical byte sequence, and tx_data/tx_last stay stable across the stalled cycles.
REQ-036: Scenario: tx_ready=0, 9 strobes of 01..09 -> fifo_count=8, overflow=1, sample 09 absent from all later output.
REQ-037: Scenario: mode changes 000->010 after the header handshake -> header 0xA0 and the next frame's header 0xA2.
REQ-038: Scenario: rst pulled low during PAYLOAD -> tx_valid=0 immediately, fifo_count=0; 4 new samples then yield a complete, correct frame.
REQ-039: Scenario: pushes every cycle while the frame drains with tx_ready=1 -> fifo_count is unchanged on push+pop cycles and no overflow occurs.
